// File: rtl/mac_pkg.sv
// Shared types for the MAC result path: result word, drain FSM states, index width helper.
package mac_pkg;

  typedef logic signed [31:0] mac_word_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

  // Row index width, never narrower than one bit so M=1 still has a port.
  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Matrix-in / row-out handshake bundle between the MAC, the drain and the writeback path.
interface mac_result_drain_if #(
  parameter int M = 4,
  parameter int N = 4
) ();
  import mac_pkg::*;

  localparam int RW = idx_w(M);

  mac_word_t [M-1:0][N-1:0] D_in;
  logic                     valid_in;
  logic                     ready_in;
  mac_word_t [N-1:0]        row_out;
  logic [RW-1:0]            row_idx_out;
  logic                     last_out;
  logic                     valid_out;
  logic                     ready_out;

  modport master (
    output D_in, valid_in, ready_out,
    input  ready_in, row_out, row_idx_out, last_out, valid_out
  );

  modport slave (
    input  D_in, valid_in, ready_out,
    output ready_in, row_out, row_idx_out, last_out, valid_out
  );

endinterface

// File: rtl/mac_drain_buffer.sv
// M x N result register array: whole-matrix load, combinational row select from stored state.
module mac_drain_buffer
  import mac_pkg::*;
#(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int RW = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load,
  input  mac_word_t [M-1:0][N-1:0] d,
  input  logic [RW-1:0]            row_sel,
  output mac_word_t [N-1:0]        row_q
);

  mac_word_t [M-1:0][N-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (load) begin
      mem_q <= d;
    end
  end

  assign row_q = mem_q[row_sel];

endmodule

// File: rtl/mac_result_drain.sv
// Buffers a whole MAC result matrix and streams it out one row per beat (MAC_DRAIN_DOUBLE_BUF_EN adds a shadow buffer).
// Latency: row 0 valid the cycle after the matrix is accepted; one row per cycle with ready_out high.
// Backpressure: rows held stable while ready_out is low; ready_in comes only from registered state.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mac_result_drain_if.slave bus
);

  localparam int            RW   = idx_w(M);
  localparam logic [RW-1:0] LAST = RW'(M - 1);

  drain_state_e  state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          acc, emit, last_beat;

  assign acc       = bus.valid_in && bus.ready_in;
  assign emit      = bus.valid_out && bus.ready_out;
  assign last_beat = emit && (row_cnt_q == LAST);

`ifdef MAC_DRAIN_DOUBLE_BUF_EN
  // Ping-pong pair: rd_sel_q marks the buffer being drained, the other is the shadow.
  logic              shadow_full_q, shadow_full_d;
  logic              rd_sel_q, rd_sel_d, wr_sel;
  mac_word_t [N-1:0] row_a, row_b;

  assign bus.ready_in = rst_ni && !shadow_full_q;
  assign wr_sel       = (state_q == IDLE) ? rd_sel_q : !rd_sel_q;

  mac_drain_buffer #(.M(M), .N(N), .RW(RW)) u_buf_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (acc && !wr_sel),
    .d       (bus.D_in),
    .row_sel (row_cnt_q),
    .row_q   (row_a)
  );

  mac_drain_buffer #(.M(M), .N(N), .RW(RW)) u_buf_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (acc && wr_sel),
    .d       (bus.D_in),
    .row_sel (row_cnt_q),
    .row_q   (row_b)
  );

  assign bus.row_out = rd_sel_q ? row_b : row_a;
`else
  assign bus.ready_in = rst_ni && (state_q == IDLE);

  mac_drain_buffer #(.M(M), .N(N), .RW(RW)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (acc),
    .d       (bus.D_in),
    .row_sel (row_cnt_q),
    .row_q   (bus.row_out)
  );
`endif

  assign bus.valid_out   = (state_q == DRAIN);
  assign bus.last_out    = (state_q == DRAIN) && (row_cnt_q == LAST);
  assign bus.row_idx_out = row_cnt_q;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
`ifdef MAC_DRAIN_DOUBLE_BUF_EN
    shadow_full_d = shadow_full_q;
    rd_sel_d      = rd_sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d   = DRAIN;
          row_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (last_beat) begin
          row_cnt_d = '0;
`ifdef MAC_DRAIN_DOUBLE_BUF_EN
          // A waiting or simultaneously arriving matrix becomes the drained one with no bubble.
          if (shadow_full_q || acc) begin
            rd_sel_d      = !rd_sel_q;
            shadow_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (emit) begin
          row_cnt_d = row_cnt_q + RW'(1);
        end
`ifdef MAC_DRAIN_DOUBLE_BUF_EN
        if (acc && !last_beat) begin
          shadow_full_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        row_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
`ifdef MAC_DRAIN_DOUBLE_BUF_EN
      shadow_full_q <= 1'b0;
      rd_sel_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
`ifdef MAC_DRAIN_DOUBLE_BUF_EN
      shadow_full_q <= shadow_full_d;
      rd_sel_q      <= rd_sel_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: a 2x2 instance and a 1x4 instance on a shared clock and reset.
module tb_mac_result_drain;

`ifdef MAC_DRAIN_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mac_result_drain_if #(.M(2), .N(2)) if2 ();
  mac_result_drain_if #(.M(1), .N(4)) if1 ();

  mac_result_drain #(.M(2), .N(2)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if2)
  );

  mac_result_drain #(.M(1), .N(4)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if1)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [1:0][1:0][31:0] mat;
  logic [1:0][1:0][31:0] mats [3];
  logic [0:0][3:0][31:0] m1;
  logic [63:0]           row0_e, row1_e;
  int                    beat_cyc [$];
  logic [63:0]           beat_row [$];
  int                    beat_idx [$];
  int                    acc_cyc  [3];
  int                    sent;
  bit                    seen;

  initial begin
    if2.D_in      = '0;
    if2.valid_in  = 1'b0;
    if2.ready_out = 1'b0;
    if1.D_in      = '0;
    if1.valid_in  = 1'b0;
    if1.ready_out = 1'b0;

    mat[0][0] = 32'd1;
    mat[0][1] = 32'hFFFF_FFFE;
    mat[1][0] = 32'd3;
    mat[1][1] = 32'h7FFF_FFFF;
    row0_e    = 64'hFFFF_FFFE_0000_0001;
    row1_e    = 64'h7FFF_FFFF_0000_0003;

    // reset values
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid",   128'(if2.valid_out),   128'(0));
    check("rst_ready",   128'(if2.ready_in),    128'(0));
    check("rst_row",     128'(if2.row_out),     128'(0));
    check("rst_idx",     128'(if2.row_idx_out), 128'(0));
    check("rst_last",    128'(if2.last_out),    128'(0));
    check("rst_m1_last", 128'(if1.last_out),    128'(0));
    check("rst_m1_rdy",  128'(if1.ready_in),    128'(0));
    check("rst_m1_row",  128'(if1.row_out),     128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready",    128'(if2.ready_in),  128'(1));
    check("rel_m1_ready", 128'(if1.ready_in),  128'(1));
    check("rel_valid",    128'(if2.valid_out), 128'(0));

    // single matrix, no backpressure
    if2.D_in      = mat;
    if2.valid_in  = 1'b1;
    if2.ready_out = 1'b1;
    @(negedge clk);
    if2.valid_in = 1'b0;
    check("t1_r0_valid", 128'(if2.valid_out),   128'(1));
    check("t1_r0_row",   128'(if2.row_out),     128'(row0_e));
    check("t1_r0_idx",   128'(if2.row_idx_out), 128'(0));
    check("t1_r0_last",  128'(if2.last_out),    128'(0));
    check("t1_busy_rdy", 128'(if2.ready_in),    128'(DB));
    @(negedge clk);
    check("t1_r1_valid", 128'(if2.valid_out),   128'(1));
    check("t1_r1_row",   128'(if2.row_out),     128'(row1_e));
    check("t1_r1_idx",   128'(if2.row_idx_out), 128'(1));
    check("t1_r1_last",  128'(if2.last_out),    128'(1));
    @(negedge clk);
    check("t1_done_valid", 128'(if2.valid_out), 128'(0));
    check("t1_done_ready", 128'(if2.ready_in),  128'(1));

    // row 0 stalled for three cycles
    if2.valid_in  = 1'b1;
    if2.ready_out = 1'b0;
    @(negedge clk);
    if2.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", 128'(if2.valid_out),   128'(1));
      check("t2_hold_row",   128'(if2.row_out),     128'(row0_e));
      check("t2_hold_idx",   128'(if2.row_idx_out), 128'(0));
      if (i < 2) @(negedge clk);
    end
    if2.ready_out = 1'b1;
    @(negedge clk);
    check("t2_r1_row",  128'(if2.row_out),     128'(row1_e));
    check("t2_r1_idx",  128'(if2.row_idx_out), 128'(1));
    check("t2_r1_last", 128'(if2.last_out),    128'(1));
    @(negedge clk);
    check("t2_no_dup", 128'(if2.valid_out), 128'(0));

    // three back-to-back matrices with valid_in held high
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          mats[k][r][c] = 32'(10 * (k + 1) + 2 * r + c);
    sent = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (if2.valid_out) begin
        beat_cyc.push_back(cyc);
        beat_row.push_back(if2.row_out);
        beat_idx.push_back(int'(if2.row_idx_out));
      end
      if (sent < 3) begin
        if2.D_in     = mats[sent];
        if2.valid_in = 1'b1;
        if (if2.ready_in) begin
          acc_cyc[sent] = cyc;
          sent++;
        end
      end else begin
        if2.valid_in = 1'b0;
      end
    end
    check("t3_sent",  128'(sent),            128'(3));
    check("t3_beats", 128'(beat_row.size()), 128'(6));
    for (int i = 0; i < beat_row.size() && i < 6; i++) begin
      check("t3_row", 128'(beat_row[i]), 128'(mats[i / 2][i % 2]));
      check("t3_idx", 128'(beat_idx[i]), 128'(i % 2));
    end
    if (sent == 3)
      check("t3_acc_gap", 128'(acc_cyc[1] - acc_cyc[0]), DB ? 128'(1) : 128'(3));
    if (beat_cyc.size() == 6)
      check("t3_span", 128'(beat_cyc[5] - beat_cyc[0]), DB ? 128'(5) : 128'(7));

    // reset in the middle of a drain
    @(negedge clk);
    if2.D_in      = mat;
    if2.valid_in  = 1'b1;
    if2.ready_out = 1'b1;
    @(negedge clk);
    if2.valid_in = 1'b0;
    check("t4_r0_idx", 128'(if2.row_idx_out), 128'(0));
    @(negedge clk);
    check("t4_r1_pending", 128'(if2.row_idx_out), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_valid", 128'(if2.valid_out), 128'(0));
    check("t4_async_last",  128'(if2.last_out),  128'(0));
    check("t4_async_ready", 128'(if2.ready_in),  128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if2.valid_out) seen = 1'b1;
    end
    check("t4_no_row1",  128'(seen),         128'(0));
    check("t4_ready",    128'(if2.ready_in), 128'(1));
    check("t4_row_zero", 128'(if2.row_out),  128'(0));

    // M=1: every beat is the last one
    m1[0][0]      = 32'hFFFF_FFFF;
    m1[0][1]      = 32'h0000_0000;
    m1[0][2]      = 32'h0000_0005;
    m1[0][3]      = 32'h8000_0000;
    if1.D_in      = m1;
    if1.valid_in  = 1'b1;
    if1.ready_out = 1'b1;
    @(negedge clk);
    if1.valid_in = 1'b0;
    check("t5_valid", 128'(if1.valid_out),   128'(1));
    check("t5_last",  128'(if1.last_out),    128'(1));
    check("t5_idx",   128'(if1.row_idx_out), 128'(0));
    check("t5_row",   128'(if1.row_out),     128'h8000_0000_0000_0005_0000_0000_FFFF_FFFF);
    @(negedge clk);
    check("t5_done_valid", 128'(if1.valid_out), 128'(0));
    check("t5_done_ready", 128'(if1.ready_in),  128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
